// File: rtl/instruction_fetch_pkg.sv
// Shared constants, state encoding and helpers for the instruction fetch stage.
// Imported by the fetch interface, the instruction memory and the fetch top.
package instruction_fetch_pkg;

  localparam int DATA_WIDTH     = 16;
  localparam int ADDR_WIDTH     = 6;
  localparam int DEPTH          = 1 << ADDR_WIDTH;
  localparam int REG_ADDR_WIDTH = 4;
  localparam int OPCODE_WIDTH   = 4;

  localparam logic [DATA_WIDTH-1:0] NOP_WORD = 16'h0000;

  // Bit positions of the decoded fields inside the instruction word
  localparam int OPCODE_LSB = 12;
  localparam int DR_LSB     = 8;
  localparam int SA_LSB     = 4;
  localparam int SB_LSB     = 0;

  // load_count saturates at DEPTH, which needs one more bit than an address
  localparam logic [ADDR_WIDTH:0] LOAD_COUNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } fetch_state_t;

  function automatic logic [ADDR_WIDTH:0] sat_inc(input logic [ADDR_WIDTH:0] count);
    return (count == LOAD_COUNT_MAX) ? count : count + 1'b1;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bus between the fetch stage and its neighbours: PC/control inputs, the host
// load port and the instruction register with its decoded fields.
interface instruction_fetch_if;
  import instruction_fetch_pkg::*;

  logic [ADDR_WIDTH-1:0]     instructionAddress;
  logic                      stall;
  logic                      flush;
  logic                      load_start;
  logic                      load_valid;
  logic                      load_ready;
  logic [ADDR_WIDTH-1:0]     load_addr;
  logic [DATA_WIDTH-1:0]     load_data;
  logic                      load_done;
  logic [ADDR_WIDTH:0]       load_count;
  logic                      fetch_run;
  logic [DATA_WIDTH-1:0]     ir;
  logic                      ir_valid;
  logic [OPCODE_WIDTH-1:0]   opcode;
  logic [REG_ADDR_WIDTH-1:0] dr;
  logic [REG_ADDR_WIDTH-1:0] sa;
  logic [REG_ADDR_WIDTH-1:0] sb;

  // master: PC, control and host side; slave: the fetch stage
  modport master (
    output instructionAddress, stall, flush, load_start,
    output load_valid, load_addr, load_data, load_done,
    input  load_ready, load_count, fetch_run,
    input  ir, ir_valid, opcode, dr, sa, sb
  );

  modport slave (
    input  instructionAddress, stall, flush, load_start,
    input  load_valid, load_addr, load_data, load_done,
    output load_ready, load_count, fetch_run,
    output ir, ir_valid, opcode, dr, sa, sb
  );

endinterface

// File: rtl/instruction_fetch_instr_mem.sv
// Single-port instruction RAM: write port used while loading, registered read
// port with enable so a stalled fetch keeps its last word.
module instr_mem
  import instruction_fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_array [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] rdata_reg;

  // Contents survive reset so a program can be re-run without reloading
  always_ff @(posedge clk) begin
    if (we) begin
      mem_array[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_reg <= NOP_WORD;
    end else if (re) begin
      rdata_reg <= mem_array[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: loads the instruction RAM from the host, then fetches the word at
// the PC each cycle into the IR, honouring stalls and inserting NOPs on flush.
module instruction_fetch
  import instruction_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  instruction_fetch_if.slave bus
);

  fetch_state_t          state_reg;
  logic [DATA_WIDTH-1:0] ir_reg;
  logic                  ir_valid_reg;
  logic                  load_ready_reg;
  logic                  fetch_run_reg;
  logic [ADDR_WIDTH:0]   load_count_reg;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  mem_we;
  logic                  mem_re;

  assign mem_we = (state_reg == LOAD) && bus.load_valid;

  // A stalled RUN keeps its read word; flush always re-reads from the jump target
  always_comb begin
    mem_re = 1'b0;
    unique case (state_reg)
      LOAD:    mem_re = 1'b0;
      PRIME:   mem_re = 1'b1;
      RUN:     mem_re = bus.flush || !bus.stall;
      FLUSH:   mem_re = !bus.stall;
      default: mem_re = 1'b0;
    endcase
  end

  instr_mem u_instr_mem (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (bus.load_addr),
    .wdata (bus.load_data),
    .re    (mem_re),
    .raddr (bus.instructionAddress),
    .rdata (read_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= LOAD;
      ir_reg         <= NOP_WORD;
      ir_valid_reg   <= 1'b0;
      load_ready_reg <= 1'b1;
      fetch_run_reg  <= 1'b0;
      load_count_reg <= '0;
    end else begin
      unique case (state_reg)
        LOAD: begin
          if (bus.load_valid) begin
            load_count_reg <= sat_inc(load_count_reg);
          end
          if (bus.load_done) begin
            state_reg      <= PRIME;
            load_ready_reg <= 1'b0;
          end
        end
        PRIME: begin
          state_reg     <= RUN;
          fetch_run_reg <= 1'b1;
        end
        RUN: begin
          if (bus.load_start) begin
            state_reg      <= LOAD;
            ir_reg         <= NOP_WORD;
            ir_valid_reg   <= 1'b0;
            load_ready_reg <= 1'b1;
            fetch_run_reg  <= 1'b0;
            load_count_reg <= '0;
          end else if (bus.flush) begin
            state_reg    <= FLUSH;
            ir_reg       <= NOP_WORD;
            ir_valid_reg <= 1'b0;
          end else if (!bus.stall) begin
            ir_reg       <= read_data;
            ir_valid_reg <= 1'b1;
          end
        end
        FLUSH: begin
          // PC keeps advancing past the target here, so fetch_run stays high
          state_reg <= RUN;
          if (!bus.stall) begin
            ir_reg       <= read_data;
            ir_valid_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= LOAD;
        end
      endcase
    end
  end

  assign bus.ir         = ir_reg;
  assign bus.ir_valid   = ir_valid_reg;
  assign bus.load_ready = load_ready_reg;
  assign bus.fetch_run  = fetch_run_reg;
  assign bus.load_count = load_count_reg;
  assign bus.opcode     = ir_reg[OPCODE_LSB +: OPCODE_WIDTH];
  assign bus.dr         = ir_reg[DR_LSB +: REG_ADDR_WIDTH];
  assign bus.sa         = ir_reg[SA_LSB +: REG_ADDR_WIDTH];
  assign bus.sb         = ir_reg[SB_LSB +: REG_ADDR_WIDTH];

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: stimulus pushes expected post-edge
// state into a queue, a negedge monitor pops and compares.
module tb_instruction_fetch;

  logic clk;
  logic reset;
  int   cyc;
  int   n_compared;
  int   n_mismatched;

  instruction_fetch_if bus ();

  instruction_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic [15:0] ir;
    logic        v;
    logic        lr;
    logic        fr;
    logic [6:0]  cnt;
  } exp_t;

  exp_t exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string name, input logic [15:0] e_ir, input logic e_v,
                              input logic e_lr, input logic e_fr, input logic [6:0] e_cnt);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.ir   = e_ir;
    e.v    = e_v;
    e.lr   = e_lr;
    e.fr   = e_fr;
    e.cnt  = e_cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every expectation scheduled for the edge just passed
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      logic [15:0] fields;
      e = exp_q.pop_front();
      fields = {bus.opcode, bus.dr, bus.sa, bus.sb};
      n_compared = n_compared + 1;
      if (e.cyc != cyc || bus.ir !== e.ir || fields !== e.ir || bus.ir_valid !== e.v ||
          bus.load_ready !== e.lr || bus.fetch_run !== e.fr || bus.load_count !== e.cnt) begin
        n_mismatched = n_mismatched + 1;
        $display("FAIL %s @cyc %0d (sched %0d): actual ir=%h fields=%h ir_valid=%b load_ready=%b fetch_run=%b load_count=%0d; required ir=%h fields=%h ir_valid=%b load_ready=%b fetch_run=%b load_count=%0d",
                 e.name, cyc, e.cyc, bus.ir, fields, bus.ir_valid, bus.load_ready, bus.fetch_run,
                 bus.load_count, e.ir, e.ir, e.v, e.lr, e.fr, e.cnt);
      end else begin
        $display("[%0d] %s ok: ir=%h ir_valid=%b load_ready=%b fetch_run=%b load_count=%0d",
                 cyc, e.name, bus.ir, bus.ir_valid, bus.load_ready, bus.fetch_run, bus.load_count);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset                  = 1'b0;
    bus.instructionAddress = '0;
    bus.stall              = 1'b0;
    bus.flush              = 1'b0;
    bus.load_start         = 1'b0;
    bus.load_valid         = 1'b0;
    bus.load_addr          = '0;
    bus.load_data          = '0;
    bus.load_done          = 1'b0;

    // Reset for two cycles
    tick();
    tick();
    expect_state("reset", 16'h0000, 0, 1, 0, 7'd0);
    reset = 1'b1;

    // Load three words
    bus.load_valid = 1'b1;
    bus.load_addr = 6'd0; bus.load_data = 16'h1234; tick(); expect_state("w0", 16'h0000, 0, 1, 0, 7'd1);
    bus.load_addr = 6'd1; bus.load_data = 16'h5678; tick(); expect_state("w1", 16'h0000, 0, 1, 0, 7'd2);
    bus.load_addr = 6'd2; bus.load_data = 16'h9ABC; tick(); expect_state("w2", 16'h0000, 0, 1, 0, 7'd3);
    bus.load_valid = 1'b0;

    // load_done -> PRIME -> RUN
    bus.load_done = 1'b1;
    tick(); expect_state("prime", 16'h0000, 0, 0, 0, 7'd3);
    bus.load_done = 1'b0;
    bus.instructionAddress = 6'd0;
    tick(); expect_state("run_entry", 16'h0000, 0, 0, 1, 7'd3);
    bus.instructionAddress = 6'd1;
    tick(); expect_state("ir_word0", 16'h1234, 1, 0, 1, 7'd3);
    bus.instructionAddress = 6'd2;
    tick(); expect_state("ir_word1", 16'h5678, 1, 0, 1, 7'd3);

    // Stall three cycles, then release
    bus.instructionAddress = 6'd3;
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_state($sformatf("stall%0d", i), 16'h5678, 1, 0, 1, 7'd3);
    end
    bus.stall = 1'b0;
    bus.instructionAddress = 6'd1;
    tick(); expect_state("stall_release", 16'h9ABC, 1, 0, 1, 7'd3);

    // Flush: PC jumps 1 -> 2, fetched word from 1 is discarded
    bus.flush = 1'b1;
    bus.instructionAddress = 6'd2;
    tick(); expect_state("flush_nop", 16'h0000, 0, 0, 1, 7'd3);
    bus.flush = 1'b0;
    bus.instructionAddress = 6'd3;
    tick(); expect_state("flush_resume", 16'h9ABC, 1, 0, 1, 7'd3);

    // Flush together with stall: jump to 0
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    bus.instructionAddress = 6'd0;
    tick(); expect_state("flush_stall_nop", 16'h0000, 0, 0, 1, 7'd3);
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    bus.instructionAddress = 6'd1;
    tick(); expect_state("flush_stall_resume", 16'h1234, 1, 0, 1, 7'd3);

    // load_start beats flush
    bus.load_start = 1'b1;
    bus.flush = 1'b1;
    tick(); expect_state("load_start", 16'h0000, 0, 1, 0, 7'd0);
    bus.load_start = 1'b0;
    bus.flush = 1'b0;

    // 70 writes to addresses 3..63 (wrapping), load_done on the last one
    for (int i = 0; i < 70; i++) begin
      bus.load_valid = 1'b1;
      bus.load_addr  = 6'(3 + (i % 61));
      bus.load_data  = 16'hA000 + 16'(i);
      bus.load_done  = (i == 69);
      tick();
      expect_state($sformatf("wr%0d", i), 16'h0000, 0, (i != 69), 0, 7'((i + 1 > 64) ? 64 : i + 1));
    end
    bus.load_valid = 1'b0;
    bus.load_done  = 1'b0;
    bus.instructionAddress = 6'd11;
    tick(); expect_state("prime2run", 16'h0000, 0, 0, 1, 7'd64);
    bus.instructionAddress = 6'd12;
    tick(); expect_state("last_write_accepted", 16'hA045, 1, 0, 1, 7'd64);
    bus.instructionAddress = 6'd13;
    tick(); expect_state("run_next", 16'hA009, 1, 0, 1, 7'd64);

    // Reset during RUN, then rerun without reloading
    reset = 1'b0;
    tick(); expect_state("reset_in_run", 16'h0000, 0, 1, 0, 7'd0);
    reset = 1'b1;
    bus.load_done = 1'b1;
    tick(); expect_state("prime_again", 16'h0000, 0, 0, 0, 7'd0);
    bus.load_done = 1'b0;
    bus.instructionAddress = 6'd0;
    tick(); expect_state("run_again", 16'h0000, 0, 0, 1, 7'd0);
    bus.instructionAddress = 6'd1;
    tick(); expect_state("mem_retained", 16'h1234, 1, 0, 1, 7'd0);

    tick();
    tick();
    if (exp_q.size() != 0) begin
      n_compared   = n_compared + 1;
      n_mismatched = n_mismatched + 1;
      $display("FAIL scoreboard_drain: actual %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
